// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and constants for the buffered UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int unsigned MIN_CLK_PER_BIT = 4;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Non-zero when the received parity bit disagrees with the selected mode.
  function automatic logic parity_error(input logic data_xor,
                                        input logic par_bit,
                                        input logic odd);
    return data_xor ^ par_bit ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Read-side bus of the receiver: FIFO pop/show-ahead data plus sticky status.
interface uart_rx_fifo_if #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
);

  logic                          rd_en;
  logic                          clr_err;
  logic [DATA_BITS-1:0]          rd_data;
  logic                          rd_valid;
  logic [$clog2(FIFO_DEPTH):0]   count;
  logic                          frame_err;
  logic                          parity_err;
  logic                          overrun;

  modport master (
    output rd_en, clr_err,
    input  rd_data, rd_valid, count, frame_err, parity_err, overrun
  );

  modport slave (
    input  rd_en, clr_err,
    output rd_data, rd_valid, count, frame_err, parity_err, overrun
  );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_push,
  input  logic [WIDTH-1:0]        i_push_data,
  input  logic                    i_pop,
  output logic [WIDTH-1:0]        o_rd_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign o_full  = (r_count == (AW + 1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_push_data;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = o_empty ? '0 : r_mem[r_rptr];
  assign o_count   = r_count;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable width/parity/bit period feeding a
// show-ahead receive FIFO, with sticky framing, parity and overrun flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_BITS   = 10,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CLK_BITS-1:0] clk_per_bit,
  input  logic                parity_en,
  input  logic                parity_odd,
  input  logic                uart_rx,
  output logic                busy,
  uart_rx_fifo_if.slave       rd_if
);

  localparam logic [CLK_BITS-1:0] MIN_CPB = CLK_BITS'(MIN_CLK_PER_BIT);

  logic                 r_sync1;
  logic                 r_rxs;
  logic                 r_rxs_d;
  rx_state_t            r_state;
  logic [CLK_BITS-1:0]  r_timer;
  logic [CLK_BITS-1:0]  r_cpb;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;
  logic                 r_frame_err;
  logic                 r_parity_err;
  logic                 r_overrun;

  logic                 w_fall;
  logic                 w_tick;
  logic [CLK_BITS-1:0]  w_cpb_eff;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_ovf;

  // Flops reset high so that reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_rxs   <= r_sync1;
      r_rxs_d <= r_rxs;
    end
  end

  assign w_fall    = r_rxs_d & ~r_rxs;
  assign w_cpb_eff = (clk_per_bit < MIN_CPB) ? MIN_CPB : clk_per_bit;
  assign w_tick    = (r_timer == CLK_BITS'(1));
  assign w_push    = (r_state == STOP) & w_tick & r_rxs & ~r_par_err;
  assign w_pop     = rd_if.rd_en & ~w_empty;
  assign w_ovf     = w_push & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      r_cpb        <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_err    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (rd_if.clr_err) begin
        r_frame_err  <= 1'b0;
        r_parity_err <= 1'b0;
      end
      if (r_state != IDLE) r_timer <= w_tick ? r_cpb : r_timer - 1'b1;

      // Error sets below come after the clear so a coincident error wins.
      unique case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state   <= START;
            r_cpb     <= w_cpb_eff;
            r_timer   <= w_cpb_eff >> 1;
            r_par_err <= 1'b0;
          end
        end
        START: begin
          if (w_tick) begin
            r_state   <= r_rxs ? IDLE : DATA;
            r_bit_cnt <= '0;
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift <= {r_rxs, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == 4'(DATA_BITS - 1)) begin
              r_state <= parity_en ? PARITY : STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (w_tick) begin
            r_par_err <= parity_error(^r_shift, r_rxs, parity_odd);
            r_state   <= STOP;
          end
        end
        STOP: begin
          if (w_tick) begin
            r_state <= IDLE;
            if (!r_rxs)         r_frame_err  <= 1'b1;
            else if (r_par_err) r_parity_err <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_overrun <= 1'b0;
    else if (w_ovf)          r_overrun <= 1'b1;
    else if (rd_if.clr_err)  r_overrun <= 1'b0;
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (r_shift),
    .i_pop       (rd_if.rd_en),
    .o_rd_data   (rd_if.rd_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (rd_if.count)
  );

  assign rd_if.rd_valid   = ~w_empty;
  assign rd_if.frame_err  = r_frame_err;
  assign rd_if.parity_err = r_parity_err;
  assign rd_if.overrun    = r_overrun;
  assign busy             = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected bytes are queued as frames are
// sent, and a monitor checks every pop the DUT performs.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] clk_per_bit;
  logic       parity_en;
  logic       parity_odd;
  logic       uart_rx;
  logic       busy;
  logic       man_rd;
  logic       auto_read;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         bit_clks = 16;
  logic [7:0] exp_q[$];

  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) rd_if ();

  uart_rx_fifo #(
    .CLK_BITS   (10),
    .DATA_BITS  (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_per_bit (clk_per_bit),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .uart_rx     (uart_rx),
    .busy        (busy),
    .rd_if       (rd_if)
  );

  always #5 clk = ~clk;

  assign rd_if.rd_en = auto_read ? rd_if.rd_valid : man_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must match the oldest expected byte.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && rd_if.rd_en && rd_if.rd_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got %0h, expected no data", rd_if.rd_data);
        end else begin
          e = exp_q.pop_front();
          check("pop_data", 32'(rd_if.rd_data), 32'(e));
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; the line is left at the stop-bit level afterwards.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic sbit, input bit pop_at_push);
    logic fr[12];
    int   nb;
    int   e;
    int   pop_edge;
    fr[0] = 1'b0;
    for (int i = 0; i < 8; i++) fr[1+i] = d[i];
    nb = 9;
    if (pen) begin
      fr[nb] = pbit;
      nb = nb + 1;
    end
    fr[nb] = sbit;
    nb = nb + 1;
    pop_edge = 3 + bit_clks / 2 + (nb - 1) * bit_clks;
    @(posedge clk);
    #1;
    e = 0;
    for (int b = 0; b < nb; b++) begin
      uart_rx = fr[b];
      for (int c = 0; c < bit_clks; c++) begin
        @(posedge clk);
        e++;
        #1;
        man_rd = pop_at_push && (e == pop_edge - 1);
      end
    end
  endtask

  task automatic pop_one();
    man_rd = 1'b1;
    idle(1);
    man_rd = 1'b0;
  endtask

  task automatic pulse_clr();
    rd_if.clr_err = 1'b1;
    idle(1);
    rd_if.clr_err = 1'b0;
  endtask

  task automatic drain();
    int t;
    auto_read = 1'b1;
    t = 0;
    while ((exp_q.size() != 0 || rd_if.rd_valid) && t < 60) begin
      @(posedge clk);
      t++;
    end
    #1;
    auto_read = 1'b0;
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    check("drain_count", 32'(rd_if.count), 32'd0);
  endtask

  function automatic logic [2:0] flags();
    return {rd_if.frame_err, rd_if.parity_err, rd_if.overrun};
  endfunction

  initial begin
    logic [7:0] vals [5];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'h55;
    uart_rx = 1'b1; clk_per_bit = 10'd16; parity_en = 1'b0; parity_odd = 1'b0;
    man_rd = 1'b0; auto_read = 1'b0; rd_if.clr_err = 1'b0;
    idle(3);
    check("rst_valid", 32'(rd_if.rd_valid), 32'd0);
    check("rst_count", 32'(rd_if.count), 32'd0);
    check("rst_data", 32'(rd_if.rd_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", 32'(flags()), 32'd0);
    rst_n = 1'b1;
    idle(4);

    // 8N1 0xA5, show-ahead then pop
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    check("a5_valid", 32'(rd_if.rd_valid), 32'd1);
    check("a5_data", 32'(rd_if.rd_data), 32'hA5);
    check("a5_count", 32'(rd_if.count), 32'd1);
    pop_one();
    check("pop_count", 32'(rd_if.count), 32'd0);
    check("pop_data_zero", 32'(rd_if.rd_data), 32'd0);

    // clk_per_bit below the minimum behaves as 4
    clk_per_bit = 10'd2; bit_clks = 4;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    drain();
    clk_per_bit = 10'd16; bit_clks = 16;

    // parity: bad even, then good even and good odd
    parity_en = 1'b1; parity_odd = 1'b0;
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(4);
    check("par_err_set", 32'(rd_if.parity_err), 32'd1);
    check("par_count", 32'(rd_if.count), 32'd0);
    check("par_frame_clear", 32'(rd_if.frame_err), 32'd0);
    pulse_clr();
    check("par_err_clr", 32'(rd_if.parity_err), 32'd0);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
    parity_odd = 1'b1;
    exp_q.push_back(8'h03);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(4);
    check("par_ok_flags", 32'(flags()), 32'd0);
    drain();
    parity_en = 1'b0; parity_odd = 1'b0;

    // 3-cycle glitch is a false start
    uart_rx = 1'b0;
    idle(3);
    uart_rx = 1'b1;
    idle(2);
    check("glitch_busy", 32'(busy), 32'd1);
    idle(30);
    check("glitch_idle", 32'(busy), 32'd0);
    check("glitch_count", 32'(rd_if.count), 32'd0);
    check("glitch_flags", 32'(flags()), 32'd0);

    // overrun: fifth byte dropped
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(vals[i]);
      send_frame(vals[i], 1'b0, 1'b0, 1'b1, 1'b0);
      idle(2);
    end
    check("ovr_set", 32'(rd_if.overrun), 32'd1);
    check("ovr_count", 32'(rd_if.count), 32'd4);
    drain();
    pulse_clr();
    check("ovr_clr", 32'(rd_if.overrun), 32'd0);

    // full FIFO with pop in the push cycle: no overrun
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(vals[i]);
      send_frame(vals[i], 1'b0, 1'b0, 1'b1, i == 4);
      idle(2);
    end
    check("simul_no_ovr", 32'(rd_if.overrun), 32'd0);
    check("simul_count", 32'(rd_if.count), 32'd4);
    drain();

    // framing error with the line held low afterwards
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(40);
    check("frm_set", 32'(rd_if.frame_err), 32'd1);
    check("frm_count", 32'(rd_if.count), 32'd0);
    check("frm_low_idle", 32'(busy), 32'd0);
    uart_rx = 1'b1;
    idle(10);
    check("frm_rise_idle", 32'(busy), 32'd0);
    pulse_clr();
    check("frm_clr", 32'(rd_if.frame_err), 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    drain();

    // asynchronous reset mid-frame with two bytes queued and a flag set
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h02, 1'b0, 1'b0, 1'b1, 1'b0);
    parity_en = 1'b1;
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0);
    parity_en = 1'b0;
    idle(4);
    check("pre_rst_count", 32'(rd_if.count), 32'd2);
    check("pre_rst_flag", 32'(rd_if.parity_err), 32'd1);
    uart_rx = 1'b0;
    idle(40);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_count", 32'(rd_if.count), 32'd0);
    check("mid_rst_valid", 32'(rd_if.rd_valid), 32'd0);
    check("mid_rst_data", 32'(rd_if.rd_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_flags", 32'(flags()), 32'd0);
    uart_rx = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(4);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    check("post_rst_count", 32'(rd_if.count), 32'd1);
    drain();
    check("final_flags", 32'(flags()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
